// File: rtl/shift_expander_pkg.sv
// Shared widths and the double-width result word type for the shift expander.
// The widths must stay consistent: OUT_W is twice DATA_W, and SHAMT_W is clog2(OUT_W)+1.
package shift_expander_pkg;

    localparam int DATA_W     = 32;
    localparam int OUT_W      = 64;
    localparam int SHAMT_W    = 7;
    localparam int NUM_STAGES = SHAMT_W - 1;

    typedef logic [OUT_W-1:0]   word_t;
    typedef logic [DATA_W-1:0]  operand_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/shift_expander_if.sv
// Operand/result bundle between a producer and the shift expander.
// The producer drives the operand side; the expander returns the registered result.
interface shift_expander_if;
    import shift_expander_pkg::*;

    logic     in_valid;
    logic     sign_ext;
    operand_t input_a;
    shamt_t   shift_index;
    word_t    output_b;
    logic     out_valid;

    modport master (
        output in_valid,
        output sign_ext,
        output input_a,
        output shift_index,
        input  output_b,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  sign_ext,
        input  input_a,
        input  shift_index,
        output output_b,
        output out_valid
    );

endinterface

// File: rtl/shift_expander_stage.sv
// One barrel-shifter rank: passes din through, or shifts it left by SHIFT when en is set.
// Vacated low bits are filled with zeros, and bits pushed past the MSB are dropped.
module shift_expander_stage
    import shift_expander_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic  en,
    input  word_t din,
    output word_t dout
);

    assign dout = en ? (din << SHIFT) : din;

endmodule

// File: rtl/shift_expander_reg.sv
// Registered 32-to-64-bit shift expander: it extends the operand, barrel-shifts it left,
// and registers the result. The latency is one cycle and the unit accepts one operation per cycle.
module shift_expander_reg #(
    parameter int DATA_W  = shift_expander_pkg::DATA_W,
    parameter int OUT_W   = shift_expander_pkg::OUT_W,
    parameter int SHAMT_W = shift_expander_pkg::SHAMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_expander_if.slave  bus
);

    localparam int NUM_STAGES = SHAMT_W - 1;

    logic [DATA_W-1:0]  operand;
    logic [SHAMT_W-1:0] shamt;
    logic [OUT_W-1:0]   extended;
    logic [OUT_W-1:0]   shifted;
    logic [OUT_W-1:0]   result_next;
    logic [OUT_W-1:0]   output_b_reg;
    logic               out_valid_reg;

    assign operand = bus.input_a;
    assign shamt   = bus.shift_index;

    // Replicate the operand MSB only when sign extension is requested.
    assign extended = {{(OUT_W-DATA_W){bus.sign_ext & operand[DATA_W-1]}}, operand};

    // Each stage k shifts by 2^k under shamt[k]; stage 0 takes the extended operand.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            logic [OUT_W-1:0] din;
            logic [OUT_W-1:0] dout;

            if (gi == 0) begin : g_first
                assign din = extended;
            end else begin : g_chain
                assign din = g_stage[gi-1].dout;
            end

            shift_expander_stage #(
                .SHIFT (1 << gi)
            ) u_stage (
                .en   (shamt[gi]),
                .din  (din),
                .dout (dout)
            );
        end
    endgenerate

    assign shifted = g_stage[NUM_STAGES-1].dout;

    // Any amount of OUT_W or more shifts every bit out of the word.
    assign result_next = shamt[SHAMT_W-1] ? '0 : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_b_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                output_b_reg <= result_next;
            end
        end
    end

    assign bus.output_b  = output_b_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_shift_expander_reg.sv
// Self-checking bench for shift_expander_reg: table vectors, a shift sweep, corner sequences
// and random traffic. All traffic is checked through an expected-result scoreboard.
module tb_shift_expander_reg;

    logic clk;
    logic rst_n;
    int   cycle;
    int   tests_run;
    int   tests_failed;

    shift_expander_if bus();

    shift_expander_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] word;
        int          cyc;
    } sb_entry_t;

    typedef struct {
        string       name;
        logic        sx;
        logic [31:0] a;
        logic [6:0]  sh;
        logic [63:0] req;
    } vec_t;

    sb_entry_t exp_q[$];
    vec_t      vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference expression: extend to 64 bits, then shift left. SV yields 0 for amounts >= 64.
    function automatic logic [63:0] ref_shift(input logic sx, input logic [31:0] a,
                                              input logic [6:0] sh);
        logic [63:0] e;
        e = {{32{sx & a[31]}}, a};
        return e << sh;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, req);
        end else begin
            $display("[TB] ok   %s: 0x%016h", name, act);
        end
    endtask

    task automatic drive(input logic v, input logic sx, input logic [31:0] a,
                         input logic [6:0] sh, input logic [63:0] req);
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.sign_ext    = sx;
        bus.input_a     = a;
        bus.shift_index = sh;
        if (v) exp_q.push_back('{word: req, cyc: cycle});
    endtask

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation,
    // one clock after the operand was presented.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                sb_entry_t e;
                e = exp_q.pop_front();
                check("scoreboard_data", bus.output_b, e.word);
                check("scoreboard_latency", 64'(cycle - e.cyc), 64'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [6:0]  rs;
        logic        rx;

        tests_run       = 0;
        tests_failed    = 0;
        cycle           = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.sign_ext    = 1'b0;
        bus.input_a     = '0;
        bus.shift_index = '0;

        vecs.push_back('{"sweep_sh0",     1'b0, 32'h3AE51959, 7'd0,   64'h0000_0000_3AE5_1959});
        vecs.push_back('{"sweep_sh4",     1'b0, 32'h3AE51959, 7'd4,   64'h0000_0003_AE51_9590});
        vecs.push_back('{"sweep_sh32",    1'b0, 32'h3AE51959, 7'd32,  64'h3AE5_1959_0000_0000});
        vecs.push_back('{"sweep_sh33",    1'b0, 32'h3AE51959, 7'd33,  64'h75CA_32B2_0000_0000});
        vecs.push_back('{"ovf_sh64",      1'b0, 32'hFFFFFFFF, 7'd64,  64'h0});
        vecs.push_back('{"ovf_sh127",     1'b1, 32'hFFFFFFFF, 7'd127, 64'h0});
        vecs.push_back('{"sext_on",       1'b1, 32'h80000001, 7'd1,   64'hFFFF_FFFF_0000_0002});
        vecs.push_back('{"sext_off",      1'b0, 32'h80000001, 7'd1,   64'h0000_0001_0000_0002});
        vecs.push_back('{"sext_sh63",     1'b1, 32'h80000000, 7'd63,  64'h0});
        vecs.push_back('{"sext_sh0",      1'b1, 32'hFFFFFFFE, 7'd0,   64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{"top_bit_sh63",  1'b0, 32'h00000001, 7'd63,  64'h8000_0000_0000_0000});
        vecs.push_back('{"sext_pos_sh8",  1'b1, 32'h7FFFFFFF, 7'd8,   64'h0000_007F_FFFF_FF00});

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        check("reset_output_b", bus.output_b, 64'h0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;

        // Constant-expected table, back to back.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].sx, vecs[i].a, vecs[i].sh, vecs[i].req);
        end

        // Full sweep 0..33 with in_valid high every cycle.
        for (int s = 0; s <= 33; s++) begin
            drive(1'b1, 1'b0, 32'h3AE51959, 7'(s), ref_shift(1'b0, 32'h3AE51959, 7'(s)));
        end
        drive(1'b0, 1'b0, 32'h0, 7'd0, 64'h0);

        // A single valid pulse, then idle with a changing operand: the output holds and
        // out_valid lasts one cycle.
        held = ref_shift(1'b0, 32'hA5A5_0F0F, 7'd12);
        drive(1'b1, 1'b0, 32'hA5A5_0F0F, 7'd12, held);
        drive(1'b0, 1'b1, 32'h1234_5678, 7'd3, 64'h0);
        @(negedge clk);
        check("pulse_out_valid_hi", 64'(bus.out_valid), 64'd1);
        check("pulse_output_b", bus.output_b, held);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, $urandom, 7'($urandom_range(0, 127)), 64'h0);
            @(negedge clk);
            check("idle_out_valid_lo", 64'(bus.out_valid), 64'd0);
            check("idle_output_b_hold", bus.output_b, held);
        end

        // An asynchronous reset between edges clears the outputs at once and drops the
        // operation in flight.
        held = ref_shift(1'b0, 32'hDEAD_BEEF, 7'd8);
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 7'd8, held);
        drive(1'b1, 1'b0, 32'h0000_00FF, 7'd40, ref_shift(1'b0, 32'h0000_00FF, 7'd40));
        @(negedge clk);
        #2;
        check("pre_reset_output_b", bus.output_b, held);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_output_b", bus.output_b, 64'h0);
        check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("in_reset_output_b", bus.output_b, 64'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 7'd0, 64'h0);
        @(negedge clk);
        check("discarded_out_valid", 64'(bus.out_valid), 64'd0);
        check("discarded_output_b", bus.output_b, 64'h0);
        drive(1'b1, 1'b1, 32'h8000_0000, 7'd31, ref_shift(1'b1, 32'h8000_0000, 7'd31));
        drive(1'b1, 1'b0, 32'h0000_0003, 7'd62, ref_shift(1'b0, 32'h0000_0003, 7'd62));

        // Random traffic with occasional idle cycles.
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rs = 7'($urandom_range(0, 127));
            rx = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                drive(1'b0, rx, ra, rs, 64'h0);
            end
            drive(1'b1, rx, ra, rs, ref_shift(rx, ra, rs));
        end

        drive(1'b0, 1'b0, 32'h0, 7'd0, 64'h0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
